// File: rtl/lut_pc_table.sv
// Programmable branch-target table: bulk stream load, single-entry writes,
// registered lookups with per-entry valid bits and a default target on miss.
module lut_pc_table #(
  parameter int IDX_W = 4,
  parameter int TGT_W = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LookupReq,
  input  logic [IDX_W-1:0] Addr,
  output logic [TGT_W-1:0] Target,
  output logic             TargetValid,
  output logic             Miss,
  input  logic             WrEn,
  input  logic [IDX_W-1:0] WrAddr,
  input  logic [TGT_W-1:0] WrData,
  input  logic             LoadStart,
  input  logic             LoadValid,
  input  logic [TGT_W-1:0] LoadData,
  output logic             LoadReady,
  output logic             Busy,
  output logic             LoadDone
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [TGT_W-1:0]   mem_q [DEPTH];
  logic [TGT_W-1:0]   mem_d [DEPTH];
  logic [TGT_W-1:0]   target_q, target_d;
  logic               tvalid_q, tvalid_d;
  logic               miss_q, miss_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TGT_W-1:0]   miss_tgt;
  logic               wr_ok;

  // Default target on a miss is the index itself, fitted to TGT_W.
  if (TGT_W > IDX_W) begin : g_zext
    assign miss_tgt = {{(TGT_W-IDX_W){1'b0}}, Addr};
  end else if (TGT_W == IDX_W) begin : g_same
    assign miss_tgt = Addr;
  end else begin : g_trunc
    assign miss_tgt = Addr[TGT_W-1:0];
  end

  assign wr_ok = (state_q == RUN) && WrEn && !LoadStart;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    target_d = target_q;
    miss_d   = miss_q;
    tvalid_d = LookupReq;
    done_d   = 1'b0;

    if (LookupReq) begin
      if (wr_ok && (WrAddr == Addr)) begin
        target_d = WrData;
        miss_d   = 1'b0;
      end else if ((state_q == RUN) && valid_q[Addr]) begin
        target_d = mem_q[Addr];
        miss_d   = 1'b0;
      end else begin
        target_d = miss_tgt;
        miss_d   = 1'b1;
      end
    end

    unique case (state_q)
      RUN: begin
        if (LoadStart) begin
          valid_d = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end else if (wr_ok) begin
          mem_d[WrAddr]   = WrData;
          valid_d[WrAddr] = 1'b1;
        end
      end
      LOAD: begin
        if (LoadValid) begin
          mem_d[cnt_q]   = LoadData;
          valid_d[cnt_q] = 1'b1;
          cnt_d          = cnt_q + IDX_ONE;
          if (cnt_q == '1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      valid_q  <= '0;
      target_q <= '0;
      tvalid_q <= 1'b0;
      miss_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      target_q <= target_d;
      tvalid_q <= tvalid_d;
      miss_q   <= miss_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Entry data needs no reset; the valid bits gate every read.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign Target      = target_q;
  assign TargetValid = tvalid_q;
  assign Miss        = miss_q;
  assign Busy        = busy_q;
  assign LoadReady   = busy_q;
  assign LoadDone    = done_q;

endmodule

// File: doc/lut_pc_table.md
# lut_pc_table

Programmable, parametrised branch-target table for the fetch stage. A narrow jump index from the instruction is mapped to an absolute instruction-memory address, as with the fixed PC lookup. The table is loaded at runtime instead of being hardwired per program: a bulk stream load fills every entry, and single-entry writes are allowed between loads. Lookups are registered, carry a per-entry valid bit, and return a defined default target on a miss.

## Interface
Parameters:
- IDX_W, 4, jump-index width.
- TGT_W, 10, target (PC) width.
- DEPTH, 2**IDX_W, entry count. Derived from IDX_W; not overridable.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-low reset.
- LookupReq  in  1  lookup request this cycle.
- Addr  in  IDX_W  lookup index.
- Target  out  TGT_W  registered lookup result.
- TargetValid  out  1  Target/Miss valid; set the cycle after an accepted lookup.
- Miss  out  1  qualified by TargetValid: entry not programmed, or table in LOAD.
- WrEn  in  1  single-entry write; honoured only in RUN.
- WrAddr  in  IDX_W  single-entry write index.
- WrData  in  TGT_W  single-entry write data.
- LoadStart  in  1  start bulk load; honoured only in RUN.
- LoadValid  in  1  load beat valid.
- LoadData  in  TGT_W  load beat data.
- LoadReady  out  1  load beat accepted when LoadValid and LoadReady are both high.
- Busy  out  1  high while in LOAD.
- LoadDone  out  1  one-cycle pulse after the final load beat.

## Operation
- Storage: DEPTH entries of TGT_W data, plus DEPTH valid bits and an IDX_W-bit load counter.
- States: RUN and LOAD.
  - Reset enters RUN with all valid bits 0 and the counter at 0.
- RUN:
  - LoadStart=1 clears all valid bits, sets the counter to 0 and moves to LOAD the next cycle.
  - WrEn=1 writes entry[WrAddr]=WrData and sets valid[WrAddr]=1.
  - If LoadStart and WrEn are both high, LoadStart wins and the write is dropped.
- LOAD:
  - LoadReady=1 and Busy=1.
  - Each accepted beat writes entry[cnt]=LoadData, sets valid[cnt]=1, then cnt++.
  - A beat accepted with cnt==DEPTH-1 returns the block to RUN the next cycle; LoadDone pulses that cycle and the counter wraps to 0.
  - In LOAD, WrEn and LoadStart are ignored. A load cannot be restarted.
  - LoadValid=0 stalls the load indefinitely with no timeout.
- Lookup, accepted every cycle LookupReq=1 in either state:
  - Hit (RUN, valid[Addr]=1): Target=entry[Addr], Miss=0.
  - Miss (valid[Addr]=0, or state is LOAD): Target=Addr zero-extended to TGT_W, Miss=1. If TGT_W<IDX_W, Target takes the low TGT_W bits of Addr instead.
  - Write bypass: in RUN, WrEn=1 with WrAddr==Addr in the same cycle returns WrData with Miss=0.
  - The lookup evaluated on the cycle of the final load beat is still a LOAD-state lookup, so it misses.
- LookupReq=0: TargetValid=0 the next cycle. Target and Miss hold their previous values.

## Timing
- Reset values: Target=0, TargetValid=0, Miss=0, LoadReady=0, Busy=0, LoadDone=0. All valid bits are 0 and the state is RUN.
- Lookup latency is 1 cycle: a request at edge N gives Target, TargetValid and Miss after edge N+1. Back-to-back lookups run at full throughput.
- A write at edge N is visible to a lookup at edge N through the bypass.
- LoadStart at edge N: Busy and LoadReady go high after edge N+1. The first beat is accepted at edge N+1 at the earliest.
- Final beat at edge M: Busy=0, LoadReady=0 and LoadDone=1 after edge M+1; LoadDone=0 after edge M+2.
- A full load takes at least DEPTH+1 cycles from LoadStart to LoadDone.
- Reset asserted mid-load: the next cycle is RUN, all entries read invalid, the counter is 0, and no LoadDone pulse is produced. Partially loaded entry data may remain, but is unreachable until it is rewritten.

## Test plan
- Reset, then lookup Addr=3: after 1 cycle TargetValid=1, Miss=1, Target=3. Every output reads 0 during reset.
- Bulk load 15,15,238,19,335,5,6,…,15 with no gaps: LoadDone is seen 17 cycles after LoadStart. Lookups then give Addr=2 -> 238, Addr=4 -> 335, Addr=15 -> 15, all with Miss=0.
- Load with LoadValid toggling every other cycle: all 16 entries are still correct. Lookups during LOAD return Miss=1 with Target=Addr, and a lookup in the final-beat cycle also misses.
- In RUN, WrEn with WrAddr=4, WrData=100, plus a same-cycle lookup of Addr=4: the result is Target=100, Miss=0, and a later lookup also returns 100. WrEn during LOAD leaves the entry unchanged.
- Reset after 6 load beats: state is RUN, Busy=0, LoadDone never pulses, and a lookup of Addr=2 gives Miss=1, Target=2.
- LoadStart and WrEn both high in the same cycle: the write is dropped and every valid bit is cleared. A second LoadStart during LOAD is ignored and the beat count continues.
